// File: rtl/snes_controller_responder_pkg.sv
// Shared definitions for the SNES pad responder: state encoding, button bit
// positions (common with the controller reader) and frame padding.
package snes_controller_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT,
        ST_DONE
    } state_e;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_N      = 4;
    localparam int BTN_S      = 5;
    localparam int BTN_W      = 6;
    localparam int BTN_E      = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;
    localparam int NUM_BUTTONS = 12;

    // Bits 12-15 of a real pad frame always read as "not pressed".
    localparam logic [3:0] FRAME_PAD = 4'b1111;

endpackage

// File: rtl/snes_controller_responder_pin_synchronizer.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall strobes
// taken from the last stage against a one-cycle-delayed copy.
module pin_synchronizer #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_async,
    output logic pin_sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], pin_async};
        prev_d = sync_q[STAGES-1];
    end

    // Preset to the pin's idle level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pin_sync = sync_q[STAGES-1];
    assign rise     = sync_q[STAGES-1] & ~prev_q;
    assign fall     = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/snes_controller_responder.sv
// Controller-side SNES serial pad: answers a host's latch/clock with the
// active-low button frame, one bit per host clock rising edge.
module snes_controller_responder
    import snes_controller_responder_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_BITS       = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        controller_latch,
    input  logic        controller_clk,
    input  logic [11:0] buttons,
    output logic        controller_dout,
    output logic        busy,
    output logic        frame_done,
    output logic [4:0]  bit_index
);

    localparam int              TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]      IDX_LAST  = 5'(NUM_BITS);
    localparam logic [4:0]      IDX_FINAL = 5'(NUM_BITS - 1);

    logic latch_sync, latch_rise, latch_fall;
    logic clk_sync, clk_rise, clk_fall;
    logic unused_pins;

    pin_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_latch_sync (
        .clk       (clk_50),
        .rst_n     (reset_n),
        .pin_async (controller_latch),
        .pin_sync  (latch_sync),
        .rise      (latch_rise),
        .fall      (latch_fall)
    );

    pin_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk_sync (
        .clk       (clk_50),
        .rst_n     (reset_n),
        .pin_async (controller_clk),
        .pin_sync  (clk_sync),
        .rise      (clk_rise),
        .fall      (clk_fall)
    );

    assign unused_pins = &{1'b0, clk_sync, clk_fall};

    logic [NUM_BITS-1:0] frame_word;
    assign frame_word = NUM_BITS'({FRAME_PAD, ~buttons});

    state_e              state_q, state_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [4:0]          bit_index_q, bit_index_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                frame_done_q, frame_done_d;
    logic                dout_q, dout_d;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_index_d  = bit_index_q;
        tmo_d        = tmo_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bit_index_d = '0;
                if (latch_sync) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                shift_d     = frame_word;
                bit_index_d = '0;
                if (latch_fall) begin
                    state_d = ST_SHIFT;
                    tmo_d   = '0;
                end
            end
            ST_SHIFT: begin
                // A host restart beats any clock edge seen in the same cycle.
                if (latch_rise) begin
                    state_d     = ST_LATCH;
                    shift_d     = frame_word;
                    bit_index_d = '0;
                end else if (clk_rise) begin
                    shift_d = {1'b0, shift_q[NUM_BITS-1:1]};
                    tmo_d   = '0;
                    if (bit_index_q != IDX_LAST) begin
                        bit_index_d = bit_index_q + 5'd1;
                    end
                    if (bit_index_q == IDX_FINAL) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = ST_IDLE;
                    shift_d     = '1;
                    bit_index_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (latch_sync) begin
                    state_d = ST_LATCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A real pad holds the line low once all bits have been clocked out.
        dout_d = (state_d == ST_IDLE) ? 1'b1 :
                 (state_d == ST_DONE) ? 1'b0 : shift_d[0];
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '1;
            bit_index_q  <= '0;
            tmo_q        <= '0;
            frame_done_q <= 1'b0;
            dout_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_index_q  <= bit_index_d;
            tmo_q        <= tmo_d;
            frame_done_q <= frame_done_d;
            dout_q       <= dout_d;
        end
    end

    assign controller_dout = dout_q;
    assign busy            = (state_q == ST_LATCH) || (state_q == ST_SHIFT);
    assign frame_done      = frame_done_q;
    assign bit_index       = bit_index_q;

endmodule

// File: tb/tb_snes_controller_responder.sv
// Self-checking bench for the SNES pad responder: a host-level pad model is
// compared against the DUT whenever outputs have settled after a pin event.
`timescale 1ns/1ps
module tb_snes_controller_responder;

    localparam int TO        = 5000;
    localparam int SETTLE    = 6;
    localparam int M_IDLE    = 0;
    localparam int M_LATCH   = 1;
    localparam int M_SHIFT   = 2;
    localparam int M_DONE    = 3;

    logic        clk_50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        controller_latch = 1'b0;
    logic        controller_clk = 1'b1;
    logic [11:0] buttons = 12'h000;
    logic        controller_dout;
    logic        busy;
    logic        frame_done;
    logic [4:0]  bit_index;

    int n_compared = 0;
    int n_mismatched = 0;

    // Host-view pad model
    int          m_mode = M_IDLE;
    int          m_idx = 0;
    int          m_quiet = 0;
    int          m_done = 0;
    logic [15:0] m_frame = 16'hFFFF;
    int          epoch = 0;
    int          dut_done_pulses = 0;

    always #10 clk_50 = ~clk_50;

    snes_controller_responder #(
        .SYNC_STAGES(2),
        .NUM_BITS(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_50           (clk_50),
        .reset_n          (reset_n),
        .controller_latch (controller_latch),
        .controller_clk   (controller_clk),
        .buttons          (buttons),
        .controller_dout  (controller_dout),
        .busy             (busy),
        .frame_done       (frame_done),
        .bit_index        (bit_index)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_dout();
        if (m_mode == M_IDLE) return 1'b1;
        if (m_mode == M_DONE) return 1'b0;
        if (m_mode == M_LATCH) return ~buttons[0];
        return (m_idx < 16) ? m_frame[m_idx] : 1'b0;
    endfunction

    // One system clock of host time; the model abandons a stalled frame.
    task automatic tick();
        @(negedge clk_50);
        if (m_mode == M_SHIFT) begin
            m_quiet++;
            if (m_quiet >= TO) begin
                m_mode = M_IDLE;
                m_idx  = 0;
                epoch++;
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_buttons(input logic [11:0] b);
        buttons = b;
        epoch++;
    endtask

    // Drive both host pins at once and apply the pad protocol rules.
    task automatic applyStimulus(input logic l, input logic c);
        logic fall_l, rise_c;
        fall_l = ~l & controller_latch;
        rise_c = c & ~controller_clk;
        controller_latch = l;
        controller_clk   = c;
        if (l && m_mode != M_LATCH) begin
            m_mode = M_LATCH;
            m_idx  = 0;
        end else if (fall_l && m_mode == M_LATCH) begin
            m_mode  = M_SHIFT;
            m_frame = {4'hF, ~buttons};
            m_quiet = 0;
        end else if (rise_c && m_mode == M_SHIFT) begin
            m_idx++;
            m_quiet = 0;
            if (m_idx == 16) begin
                m_mode = M_DONE;
                m_done++;
            end
        end
        epoch++;
    endtask

    // Latch (buttons change mid-latch), then nclk host clocks sampling dout.
    task automatic host_frame(input logic [11:0] btn, input int half, input int nclk,
                              output logic [15:0] sampled);
        sampled = 16'h0000;
        set_buttons(~btn);
        applyStimulus(1'b1, 1'b1);
        wait_cycles(half);
        set_buttons(btn);
        wait_cycles(half);
        applyStimulus(1'b0, 1'b1);
        wait_cycles(half);
        for (int i = 0; i < nclk; i++) begin
            sampled[i] = controller_dout;
            applyStimulus(1'b0, 1'b0);
            wait_cycles(half);
            applyStimulus(1'b0, 1'b1);
            wait_cycles(half);
        end
    endtask

    // Continuous compare once outputs have settled after the last model event.
    initial begin
        int settle = 0;
        int last_epoch = 0;
        forever begin
            @(posedge clk_50);
            #1;
            if (frame_done === 1'b1) dut_done_pulses++;
            if (epoch != last_epoch) begin
                settle = 0;
                last_epoch = epoch;
            end else if (settle < SETTLE) begin
                settle++;
            end
            if (settle >= SETTLE && reset_n) begin
                checkOutput("dout", 32'(controller_dout), 32'(model_dout()));
                checkOutput("busy", 32'(busy), 32'((m_mode == M_LATCH) || (m_mode == M_SHIFT)));
                checkOutput("bit_index", 32'(bit_index), 32'(m_idx));
            end
        end
    end

    initial begin
        logic [15:0] s;

        wait_cycles(4);
        checkOutput("reset_dout", 32'(controller_dout), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset_bit_index", 32'(bit_index), 32'd0);
        reset_n = 1'b1;
        epoch++;
        wait_cycles(20);

        // Standard frame at 6 us half-period, B pressed
        host_frame(12'h001, 300, 16, s);
        checkOutput("frame_B_bits", 32'(s), 32'h0000FFFE);
        checkOutput("frame_B_pulses", 32'(dut_done_pulses), 32'd1);
        checkOutput("frame_B_dout_after", 32'(controller_dout), 32'd0);
        checkOutput("frame_B_busy_after", 32'(busy), 32'd0);

        // L and R pressed; extra clocks after the frame must not move bit_index
        host_frame(12'hC00, 40, 16, s);
        checkOutput("frame_LR_bits", 32'(s), 32'h0000F3FF);
        applyStimulus(1'b0, 1'b0);
        wait_cycles(40);
        applyStimulus(1'b0, 1'b1);
        wait_cycles(40);
        checkOutput("frame_LR_index", 32'(bit_index), 32'd16);
        checkOutput("frame_LR_pulses", 32'(dut_done_pulses), 32'd2);

        // Host restarts after 5 clocks with N pressed
        host_frame(12'h3C3, 40, 5, s);
        checkOutput("abort_index", 32'(bit_index), 32'd5);
        host_frame(12'h010, 40, 16, s);
        checkOutput("restart_bits", 32'(s), 32'h0000FFEF);
        checkOutput("restart_pulses", 32'(dut_done_pulses), 32'd3);

        // Stalled frame: 3 clocks then silence past the timeout
        host_frame(12'h555, 40, 3, s);
        checkOutput("stall_busy", 32'(busy), 32'd1);
        checkOutput("stall_index", 32'(bit_index), 32'd3);
        wait_cycles(TO + TO / 5);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        checkOutput("timeout_dout", 32'(controller_dout), 32'd1);
        checkOutput("timeout_pulses", 32'(dut_done_pulses), 32'd3);

        // Latch fall coincident with clock rise: no shift on that edge
        set_buttons(12'h002);
        applyStimulus(1'b1, 1'b0);
        wait_cycles(80);
        applyStimulus(1'b0, 1'b1);
        wait_cycles(40);
        checkOutput("coincide_dout", 32'(controller_dout), 32'd1);
        checkOutput("coincide_index", 32'(bit_index), 32'd0);
        applyStimulus(1'b0, 1'b0);
        wait_cycles(40);
        applyStimulus(1'b0, 1'b1);
        wait_cycles(40);
        checkOutput("coincide_Y_dout", 32'(controller_dout), 32'd0);
        checkOutput("coincide_Y_index", 32'(bit_index), 32'd1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b0);
            wait_cycles(40);
            applyStimulus(1'b0, 1'b1);
            wait_cycles(40);
        end
        checkOutput("coincide_pulses", 32'(dut_done_pulses), 32'd4);

        // Asynchronous reset during bit 7
        host_frame(12'h3C3, 40, 7, s);
        #3;
        reset_n = 1'b0;
        m_mode = M_IDLE;
        m_idx = 0;
        epoch++;
        #1;
        checkOutput("midreset_dout", 32'(controller_dout), 32'd1);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_index", 32'(bit_index), 32'd0);
        wait_cycles(3);
        reset_n = 1'b1;
        epoch++;
        wait_cycles(10);
        host_frame(12'h0A5, 40, 16, s);
        checkOutput("postreset_bits", 32'(s), 32'h0000FF5A);
        checkOutput("postreset_index", 32'(bit_index), 32'd16);
        checkOutput("total_pulses", 32'(dut_done_pulses), 32'(m_done));

        wait_cycles(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/snes_controller_responder.md
Name: snes_controller_responder

Overview:
- Controller-side end of the SNES serial pad protocol. It answers a host that drives latch and clock and samples the data line.
- It lets the board emulate a pad, for example to replay paddle inputs into a second board's controller reader, or to act as a loopback target on HDR1 during bring-up.
- Sits beside the existing controller-reader logic. It is clocked by the 50 MHz system clock and treats the latch and clock pins as asynchronous inputs.

Parameters:
- SYNC_STAGES, 2, flops in each pin synchronizer (minimum 2).
- NUM_BITS, 16, serial bits per frame.
- TIMEOUT_CYCLES, 50000, clk_50 cycles (1 ms) without a controller_clk rising edge before a partial frame is abandoned.

Ports:
- clk_50  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- controller_latch  in  1  host latch pin, asynchronous, active high.
- controller_clk  in  1  host clock pin, asynchronous, idles high.
- buttons  in  12  pressed=1, bit order {R,L,X,A,E,W,S,N,START,SELECT,Y,B}; B is bit 0.
- controller_dout  out  1  serial data to host, active-low (0 = pressed).
- busy  out  1  high while a frame is latched or shifting.
- frame_done  out  1  one-cycle pulse after the NUM_BITS-th shift.
- bit_index  out  5  number of shifts completed in the current frame.

Behaviour:
- Reset (async assert, sync release): state IDLE, controller_dout=1, busy=0, frame_done=0, bit_index=0, shift register all 1s, synchronizer flops preset to the pin idle levels (latch=0, clk=1).
- Both pins go through SYNC_STAGES flops. Edges are detected on the last stage against a one-cycle-delayed copy.
- Frame word: {4'b1111, ~buttons}. Bits 12-15 are always 1 (unpressed); bit 0 = ~B.
- controller_dout is registered from shift_reg[0], so a pin edge reaches dout SYNC_STAGES+1 cycles later (3 cycles by default).
- States:
  - IDLE: dout=1, busy=0. Synced latch high -> LATCH.
  - LATCH: the shift register reloads the frame word every cycle, so live button changes are tracked. busy=1, bit_index=0. Synced latch falling edge -> SHIFT.
  - SHIFT: on each synced controller_clk rising edge, shift right with 0 fill and bit_index += 1. When bit_index reaches NUM_BITS -> DONE and frame_done pulses that cycle. Falling edges of controller_clk are ignored.
  - DONE: dout=0 (genuine-pad behaviour after 16 bits), busy=0. Further clock edges are ignored and do not move bit_index. Synced latch high -> LATCH.
- Timeout: a counter clears on entering SHIFT and on each clock rising edge. When it reaches TIMEOUT_CYCLES-1 in SHIFT -> IDLE, with no frame_done pulse.
- Latch rising while in SHIFT (host restarts mid-frame) -> LATCH immediately. The shift register reloads and bit_index clears.
- Latch falling edge and clk rising edge seen in the same cycle: the latch edge wins and the shift register is not shifted that cycle. The first clock edge must arrive on a later cycle to count.
- Clock edges while in LATCH or IDLE do not shift.
- buttons is sampled every cycle in LATCH. The value frozen for the frame is the one present the cycle before SHIFT is entered.
- Widths:
  - bit_index saturates at NUM_BITS.
  - The timeout counter is $clog2(TIMEOUT_CYCLES) bits.
  - The shift register is NUM_BITS wide.
- Asynchronous reset asserted mid-frame: all outputs return to their reset values at once. The next frame starts only on a fresh latch rising edge after release.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, LATCH, SHIFT, DONE);
  - button bit-position constants (BTN_B=0 ... BTN_R=11), shared with the reader;
  - the frame padding constant 4'b1111.
- One natural sub-module: pin_synchronizer (parameterised depth, reset value, and edge-detect outputs rise and fall), instantiated twice.

Test Plan:
- Reset, then standard frame: buttons=12'h001 (B pressed), 12 us latch, 16 clocks at 6 us half-period -> sampled bits 0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1; frame_done one pulse; dout=0 afterwards.
- buttons=12'hC00 (L and R pressed) -> bits 10 and 11 sampled 0, all others 1; bit_index=16 at end.
- Latch re-asserted after 5 clocks with buttons changed to 12'h010 -> new frame starts at bit 0; bit 4 (N) is 0; no frame_done from the aborted frame.
- Latch released, 3 clocks, then none for 1.2 ms -> returns to IDLE; busy=0; dout=1; frame_done never pulses.
- Latch fall and clk rise coincident on the pins -> no shift; the first subsequent clock rise outputs bit 1 (Y).
- reset_n pulsed low during bit 7 -> dout=1 and busy=0 asynchronously; the next latch+16 clocks frame is correct.
